// File: rtl/de2_115_web_qsys_sd_cmd_seq.sv
// SD-card command-line sequencer behind a four-register Avalon-MM slave: it sends one 48-bit command and optionally captures its 48-bit response.
// Build option: define SD_CMD_CRC_CHECK_EN to check the CRC7 of received responses (crc_err).
module de2_115_web_qsys_sd_cmd_seq #(
  parameter int CLK_DIV      = 125,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  inout  wire         bidir_port,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam int DW = $clog2(CLK_DIV + 1);

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t      state_q;
  logic [DW-1:0] div_q;
  logic        sd_clk_q;
  logic [31:0] arg_q;
  logic [31:0] resp_q;
  logic [47:0] frame_q;
  logic [46:0] rx_q;
  logic [5:0]  bit_cnt_q;
  logic [15:0] cnt_q;
  logic [5:0]  resp_idx_q;
  logic        resp_en_q;
  logic        oe_q;
  logic        cmd_q;
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic        crc_err_q;
  logic        end_err_q;

  logic        toggle;
  logic        fall_tick;
  logic        rise_tick;
  logic        wr;
  logic        start_req;
  logic        clr_req;
  logic        line_in;
  logic [39:0] tx_hdr;
  logic [47:0] rx_next;

  assign toggle    = (div_q == DW'(CLK_DIV - 1));
  assign fall_tick = toggle & sd_clk_q;
  assign rise_tick = toggle & ~sd_clk_q;
  assign sd_clk    = sd_clk_q;
  assign state_o   = state_q;

  assign wr        = chipselect & ~write_n;
  assign start_req = wr && (address == 2'd1) && writedata[7] && (state_q == S_IDLE);
  assign clr_req   = wr && (address == 2'd2) && writedata[1];

  // The line is only driven while a frame is being shifted out; otherwise the external pull-up holds it high.
  assign bidir_port = oe_q ? cmd_q : 1'bz;
  assign line_in    = bidir_port;

  assign tx_hdr  = {2'b01, writedata[5:0], arg_q};
  assign rx_next = {rx_q, line_in};

`ifndef SD_CMD_CRC_CHECK_EN
  logic unused_rx_bits;
  assign unused_rx_bits = ^{rx_next[47:46], rx_next[7:1]};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      sd_clk_q <= 1'b0;
    end else if (toggle) begin
      div_q    <= '0;
      sd_clk_q <= ~sd_clk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arg_q <= '0;
    end else if (wr && (address == 2'd0)) begin
      arg_q <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      resp_idx_q <= '0;
      resp_en_q  <= 1'b0;
      oe_q       <= 1'b0;
      cmd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      // Clears come first so that a flag set later in this cycle overrides them.
      if (clr_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        crc_err_q <= 1'b0;
        end_err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            resp_en_q <= writedata[6];
            frame_q   <= {tx_hdr, crc7(tx_hdr), 1'b1};
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (fall_tick) begin
            if (bit_cnt_q == 6'd48) begin
              oe_q      <= 1'b0;
              cmd_q     <= 1'b1;
              bit_cnt_q <= '0;
              cnt_q     <= '0;
              state_q   <= resp_en_q ? S_WAIT : S_GAP;
            end else begin
              oe_q      <= 1'b1;
              cmd_q     <= frame_q[47];
              frame_q   <= {frame_q[46:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        S_WAIT: begin
          if (rise_tick) begin
            if (!line_in) begin
              rx_q      <= '0;
              bit_cnt_q <= 6'd1;
              state_q   <= S_RECV;
            end else if (cnt_q == 16'(RESP_TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= S_GAP;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        S_RECV: begin
          if (rise_tick) begin
            rx_q <= rx_next[46:0];
            if (bit_cnt_q == 6'd47) begin
              resp_idx_q <= rx_next[45:40];
              resp_q     <= rx_next[39:8];
              if (!rx_next[0]) end_err_q <= 1'b1;
`ifdef SD_CMD_CRC_CHECK_EN
              if (crc7(rx_next[47:8]) != rx_next[7:1]) crc_err_q <= 1'b1;
`endif
              cnt_q   <= '0;
              state_q <= S_GAP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end
        end
        S_GAP: begin
          if (rise_tick) begin
            if (cnt_q == 16'd7) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= arg_q;
        2'd2:    readdata <= {18'd0, resp_idx_q, 3'd0, end_err_q, crc_err_q,
                              timeout_q, done_q, busy_q};
        2'd3:    readdata <= resp_q;
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_de2_115_web_qsys_sd_cmd_seq.sv
// Bench for de2_115_web_qsys_sd_cmd_seq: register reads and transmitted frames are checked against expected values queued by the stimulus.
`timescale 1ns/1ps
module tb_de2_115_web_qsys_sd_cmd_seq;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sd_clk;
  logic [2:0]  state_o;
  logic        card_oe;
  logic        card_bit;
  wire         sd_cmd;

  assign sd_cmd = card_oe ? card_bit : 1'bz;
  pullup (sd_cmd);

  de2_115_web_qsys_sd_cmd_seq #(.CLK_DIV(2), .RESP_TIMEOUT(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .bidir_port (sd_cmd),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [47:0] exp_fr_q[$];

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Register-read monitor: a read issued before posedge N is compared at negedge N+1.
  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= reset_n & chipselect & write_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", readdata);
      end else begin
        check(name_q.pop_front(), {16'd0, readdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Frame monitor: samples the line just after each sd_clk rise while the DUT is sending.
  logic        sd_prev = 1'b0;
  logic [2:0]  st_prev = 3'd0;
  logic [47:0] cap_sr;
  int          cap_cnt = 0;
  int          wait_rises = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      cap_cnt = 0;
      sd_prev = 1'b0;
      st_prev = ST_IDLE;
    end else begin
      if (sd_clk && !sd_prev) begin
        if (st_prev == ST_WAIT) wait_rises++;
        if (cap_cnt == 0) begin
          if (state_o == ST_SEND && sd_cmd == 1'b0) begin
            cap_sr  = 48'd0;
            cap_cnt = 1;
          end
        end else begin
          cap_sr = {cap_sr[46:0], sd_cmd};
          cap_cnt++;
          if (cap_cnt == 48) begin
            cap_cnt = 0;
            if (exp_fr_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_frame: got %h expected none", cap_sr);
            end else begin
              check("frame", cap_sr, exp_fr_q.pop_front());
            end
          end
        end
      end
      sd_prev = sd_clk;
      st_prev = state_o;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state_o != ST_IDLE && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic wait_sd_fall();
    logic p;
    int   n;
    p = sd_clk;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (p && !sd_clk) return;
      p = sd_clk;
      n++;
    end
    total++;
    bad++;
    $display("FAIL sd_clk_stalled: got no fall in %0d cycles expected toggling", n);
  endtask

  // Card model: replies once the sequencer starts listening, changing bits on sd_clk falls.
  task automatic card_respond(input logic [47:0] r);
    int n;
    n = 0;
    while (state_o != ST_WAIT && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL card_wait: got state %0d expected WAIT", state_o);
      return;
    end
    for (int i = 47; i >= 0; i--) begin
      wait_sd_fall();
      card_oe  = 1'b1;
      card_bit = r[i];
    end
    wait_sd_fall();
    card_oe = 1'b0;
  endtask

  task automatic run_cmd8(input logic [47:0] resp, input logic [31:0] exp_status, input string name);
    bus_write(2'd0, 32'h0000_01AA);
    exp_fr_q.push_back(48'h48000001AA87);
    bus_write(2'd1, 32'h0000_00C8);
    fork
      card_respond(resp);
    join_none
    wait_idle(name);
    bus_read(2'd3, 32'h0000_01AA, {name, "_resp"});
    bus_read(2'd2, exp_status, {name, "_status"});
  endtask

  initial begin
    int n;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'd0; card_oe = 1'b0; card_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sd_clk", {47'd0, sd_clk}, 48'd0);
    check("rst_line", {47'd0, sd_cmd}, 48'd1);
    check("rst_state", {45'd0, state_o}, 48'd0);
    check("rst_readdata", {16'd0, readdata}, 48'd0);
    reset_n = 1'b1;
    bus_read(2'd0, 32'd0, "rst_arg");
    bus_read(2'd1, 32'd0, "rst_ctrl");
    bus_read(2'd2, 32'd0, "rst_status");
    bus_read(2'd3, 32'd0, "rst_resp");

    // CMD0, no response expected.
    bus_write(2'd0, 32'd0);
    exp_fr_q.push_back(48'h400000000095);
    bus_write(2'd1, 32'h0000_0080);
    bus_read(2'd2, 32'h0000_0001, "cmd0_busy");
    wait_idle("cmd0_idle");
    bus_read(2'd2, 32'h0000_0002, "cmd0_status");
    check("cmd0_line_released", {47'd0, sd_cmd}, 48'd1);

    // CMD8 with a good R7 reply.
    run_cmd8(48'h08000001AA13, 32'h0000_0802, "cmd8");
    bus_write(2'd2, 32'h0000_0002);
    bus_read(2'd2, 32'h0000_0800, "w1c_status");

    // CMD8 with a silent card.
    wait_rises = 0;
    bus_write(2'd0, 32'h0000_01AA);
    exp_fr_q.push_back(48'h48000001AA87);
    bus_write(2'd1, 32'h0000_00C8);
    wait_idle("timeout_idle");
    check("timeout_rises", 48'(wait_rises), 48'd64);
    bus_read(2'd2, 32'h0000_0806, "timeout_status");
    bus_read(2'd3, 32'h0000_01AA, "timeout_resp");

`ifdef SD_CMD_CRC_CHECK_EN
    run_cmd8(48'h08000001AA15, 32'h0000_080A, "crc_bad");
`else
    run_cmd8(48'h08000001AA15, 32'h0000_0802, "crc_bad");
`endif
    run_cmd8(48'h08000001AA12, 32'h0000_0812, "end_bad");

    // Second start and ARG rewrite while a frame is in flight.
    bus_write(2'd0, 32'd0);
    exp_fr_q.push_back(48'h400000000095);
    bus_write(2'd1, 32'h0000_0080);
    n = 0;
    while (cap_cnt < 5 && n < 500) begin @(negedge clk); n++; end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'h0000_00BF);
    wait_idle("busy_idle");
    repeat (300) @(negedge clk);
    bus_read(2'd0, 32'hFFFF_FFFF, "busy_arg");
    bus_read(2'd2, 32'h0000_0802, "busy_status");

    // Reset in the middle of a frame.
    bus_write(2'd0, 32'h0000_01AA);
    exp_fr_q.push_back(48'h48000001AA87);
    bus_write(2'd1, 32'h0000_0088);
    n = 0;
    while (cap_cnt < 20 && n < 500) begin @(negedge clk); n++; end
    check("midrst_reached_bit20", {47'd0, cap_cnt >= 20}, 48'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_line", {47'd0, sd_cmd}, 48'd1);
    check("midrst_sd_clk", {47'd0, sd_clk}, 48'd0);
    check("midrst_state", {45'd0, state_o}, 48'd0);
    check("midrst_readdata", {16'd0, readdata}, 48'd0);
    void'(exp_fr_q.pop_back());
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, 32'd0, "midrst_status");
    bus_read(2'd0, 32'd0, "midrst_arg");
    bus_read(2'd3, 32'd0, "midrst_resp");
    exp_fr_q.push_back(48'h400000000095);
    bus_write(2'd1, 32'h0000_0080);
    wait_idle("after_rst_idle");
    bus_read(2'd2, 32'h0000_0002, "after_rst_status");

    repeat (4) @(negedge clk);
    check("frames_left", 48'(exp_fr_q.size()), 48'd0);
    check("reads_left", 48'(exp_q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
